// File: rtl/pcs_tx_gearbox.sv
// Transmit gearbox: packs 66-bit blocks (two 32-bit beats) into a continuous 32-bit SERDES stream.
// Define PCS_TX_SCRAMBLE_EN to scramble payload bits with G(x)=1+x^39+x^58.
module pcs_tx_gearbox #(
  parameter int DATA_W = 32,
  parameter int HEAD_W = 2,
  parameter int SEQ_W  = 7
) (
  input  logic              clk,
  input  logic              nreset,
  output logic              ready_o,
  output logic              part_o,
  input  logic              head_v_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              align_err_o
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int CAT_W  = RES_W + DATA_W;
  localparam int ADD_W  = DATA_W + HEAD_W;
  localparam int RCNT_W = $clog2(CAT_W + 1);
  localparam logic [SEQ_W-1:0] STALL_CNT = SEQ_W'(64);
  localparam logic [SEQ_W-1:0] LAST_CNT  = SEQ_W'(65);

  logic [SEQ_W-1:0]  cnt_q;
  logic              part_q;
  logic [RES_W-1:0]  res_q;
  logic [RCNT_W-1:0] res_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              accept;
  logic [DATA_W-1:0] payload;
  logic [ADD_W-1:0]  add_bits;
  logic [RCNT_W-1:0] add_cnt;
  logic [CAT_W-1:0]  cat;
  logic [RCNT_W-1:0] cat_cnt;

  assign ready_o     = (cnt_q < STALL_CNT);
  assign accept      = ready_o;
  assign part_o      = part_q;
  assign data_o      = data_q;
  assign align_err_o = err_q;

`ifdef PCS_TX_SCRAMBLE_EN
  logic [57:0] scr_q;
  logic [57:0] scr_d;

  // Serial scrambler unrolled over one beat in wire order; state moves only on accepted beats.
  always_comb begin
    scr_d   = scr_q;
    payload = data_i;
    for (int i = 0; i < DATA_W; i++) begin
      payload[i] = data_i[i] ^ scr_d[38] ^ scr_d[57];
      scr_d      = {scr_d[56:0], payload[i]};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      scr_q <= '1;
    end else if (accept) begin
      scr_q <= scr_d;
    end
  end
`else
  assign payload = data_i;
`endif

  // New bits land just above the residue; the low word of the concatenation goes out next edge.
  always_comb begin
    add_bits = '0;
    add_cnt  = '0;
    if (accept) begin
      if (!part_q) begin
        add_bits = {payload, head_i};
        add_cnt  = RCNT_W'(ADD_W);
      end else begin
        add_bits = {{HEAD_W{1'b0}}, payload};
        add_cnt  = RCNT_W'(DATA_W);
      end
    end
    cat     = {{DATA_W{1'b0}}, res_q} | ({{(CAT_W-ADD_W){1'b0}}, add_bits} << res_cnt_q);
    cat_cnt = res_cnt_q + add_cnt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q     <= '0;
      part_q    <= 1'b0;
      res_q     <= '0;
      res_cnt_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= (cnt_q == LAST_CNT) ? '0 : cnt_q + SEQ_W'(1);
      if (accept) begin
        part_q <= ~part_q;
      end
      data_q    <= cat[DATA_W-1:0];
      res_q     <= cat[CAT_W-1:DATA_W];
      res_cnt_q <= cat_cnt - RCNT_W'(DATA_W);
      err_q     <= accept && (head_v_i == part_q);
    end
  end

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Self-checking bench for pcs_tx_gearbox: hand-computed vector table plus a bit-queue stream model.
module tb_pcs_tx_gearbox;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        ready_o;
  logic        part_o;
  logic        head_v_i = 1'b0;
  logic [1:0]  head_i = 2'b00;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        align_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcs_tx_gearbox dut (
    .clk         (clk),
    .nreset      (nreset),
    .ready_o     (ready_o),
    .part_o      (part_o),
    .head_v_i    (head_v_i),
    .head_i      (head_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .align_err_o (align_err_o)
  );

  // Reference model: the wire stream as a queue of bits, 32 popped per cycle.
  int          m_cnt;
  bit          m_part;
  bit          m_q[$];
  logic [57:0] m_scr;
  logic [31:0] exp_data;
  logic        exp_err;

  typedef struct {
    bit          rst;
    bit          hv;
    logic [1:0]  hd;
    logic [31:0] d;
    logic [31:0] exp_d;
    bit          exp_part;
    bit          exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic modelReset();
    m_cnt = 0;
    m_part = 1'b0;
    m_q.delete();
    m_scr = '1;
    exp_data = 32'h0;
    exp_err = 1'b0;
  endtask

  task automatic modelStep(input bit v, input logic [1:0] h, input logic [31:0] d);
    exp_err = 1'b0;
    if (m_cnt < 64) begin
      exp_err = (v == m_part);
      if (!m_part) begin
        m_q.push_back(h[0]);
        m_q.push_back(h[1]);
      end
      for (int i = 0; i < 32; i++) begin
        bit b;
        b = d[i];
`ifdef PCS_TX_SCRAMBLE_EN
        b = b ^ m_scr[38] ^ m_scr[57];
        m_scr = {m_scr[56:0], b};
`endif
        m_q.push_back(b);
      end
      m_part = !m_part;
    end
    for (int i = 0; i < 32; i++) begin
      exp_data[i] = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
    end
    m_cnt = (m_cnt == 65) ? 0 : m_cnt + 1;
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] h, input logic [31:0] d);
    head_v_i = v;
    head_i = h;
    data_i = d;
    modelStep(v, h, d);
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_data"}, data_o, exp_data);
    checkOutput({tag, "_err"}, {31'b0, align_err_o}, {31'b0, exp_err});
    checkOutput({tag, "_part"}, {31'b0, part_o}, {31'b0, m_part});
    checkOutput({tag, "_ready"}, {31'b0, ready_o}, {31'b0, (m_cnt < 64)});
  endtask

  task automatic doReset();
    nreset = 1'b0;
    head_v_i = 1'b0;
    head_i = 2'b00;
    data_i = 32'h0;
    #2;
    checkOutput("rst_data", data_o, 32'h0);
    checkOutput("rst_ready", {31'b0, ready_o}, 32'h1);
    checkOutput("rst_part", {31'b0, part_o}, 32'h0);
    checkOutput("rst_err", {31'b0, align_err_o}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    modelReset();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'b01, 32'h0,        32'h0000_0001, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 32'h0,        32'h0000_0004, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h0,        32'h0000_0010, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 32'h0,        32'h0000_001F, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'b01, 32'h0,        32'h0000_0000, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].hv, vecs[i].hd, vecs[i].d);
`ifndef PCS_TX_SCRAMBLE_EN
      checkOutput($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
`endif
      checkOutput($sformatf("vec%0d_part", i), {31'b0, part_o}, {31'b0, vecs[i].exp_part});
      checkOutput($sformatf("vec%0d_err", i), {31'b0, align_err_o}, {31'b0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_ready", i), {31'b0, ready_o}, 32'h1);
      checkModel($sformatf("vec%0d_model", i));
    end

    // Three full periods; garbage on stall cycles, one misaligned head_v on a part 1 beat.
    doReset();
    for (int c = 0; c < 3 * 66; c++) begin
      int cyc;
      int blk;
      bit v;
      logic [1:0] h;
      logic [31:0] d;
      cyc = c % 66;
      blk = (c / 66) * 32 + cyc / 2;
      if (cyc < 64) begin
        h = blk[0] ? 2'b10 : 2'b01;
        v = !m_part;
        if (c == 101) v = 1'b1;
        d = (c < 66) ? 32'hFFFF_FFFF : $urandom;
      end else begin
        h = 2'($urandom);
        v = 1'($urandom);
        d = $urandom | 32'h8000_0001;
      end
      applyStimulus(v, h, d);
      checkOutput($sformatf("run_c%0d_ready", c), {31'b0, ready_o}, {31'b0, (((c + 1) % 66) < 64)});
      checkModel($sformatf("run_c%0d", c));
    end

    // Reset pulled mid-period at cnt_q=37.
    doReset();
    for (int c = 0; c < 37; c++) begin
      applyStimulus(!m_part, m_part ? 2'b01 : 2'b10, $urandom | 32'h0000_00F0);
      checkModel($sformatf("pre_c%0d", c));
    end
    doReset();
    checkOutput("post_rst_ready", {31'b0, ready_o}, 32'h1);
    checkOutput("post_rst_part", {31'b0, part_o}, 32'h0);
    applyStimulus(1'b1, 2'b01, 32'h0);
`ifndef PCS_TX_SCRAMBLE_EN
    checkOutput("post_rst_word0", data_o, 32'h0000_0001);
`endif
    checkModel("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
